// File: rtl/stage_skid_buf.sv
// Two-entry skid buffer (main + skid) with synchronous flush and saturating flush-drop counter.
// Latency: one cycle from accept into an empty buffer to out_valid.
// Backpressure: in_ready decoded from registered state only (low when FULL); no path from out_ready.
module stage_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [15:0]      drop_q, drop_d;
  logic [16:0]      drop_sum;
  logic             accept, pop;

  // Handshake outputs come straight from the state register; the state code doubles as occupancy.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;
  assign drop_cnt  = drop_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Flush adds the pre-flush occupancy to the drop counter, clamping at all-ones.
  assign drop_sum = {1'b0, drop_q} + {15'd0, occupancy};
  assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  // Next-state and datapath steering; flush overrides any same-cycle accept or pop.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // Input is ignored here: in_ready is low so nothing can be accepted.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State, payload and drop-counter registers; reset discards entries without counting them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      if (flush) begin
        drop_q <= drop_d;
      end
    end
  end

endmodule

// File: tb/tb_stage_skid_buf.sv
// Directed-vector and scoreboard bench for stage_skid_buf.
// Inputs change and outputs are sampled on the falling clk edge.
// A random valid/ready phase checks ordering against a queue model.
module tb_stage_skid_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  stage_skid_buf #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
    logic        ir;
    logic [15:0] drop;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [31:0] od,
                         input logic [1:0] occ, input logic ir, input logic [15:0] drop);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".out_data"},  out_data, od);
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    chk({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, ir});
    chk({tag, ".drop_cnt"},  {16'd0, drop_cnt}, {16'd0, drop});
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_and_flush();
    step(1'b1, 32'hC0, 1'b0, 1'b0);
    step(1'b1, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b1, 1'b1);
  endtask

  logic [31:0] q[$];
  logic        acc;
  logic        pp;

  initial begin
    // streaming
    vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b0,  1'b1, 32'h11, 2'd1, 1'b1, 16'd0};
    vecs[1]  = '{1'b1, 32'h22, 1'b1, 1'b0,  1'b1, 32'h22, 2'd1, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 32'h33, 1'b1, 1'b0,  1'b1, 32'h33, 2'd1, 1'b1, 16'd0};
    vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0,  1'b0, 32'h33, 2'd0, 1'b1, 16'd0};
    // backpressure: 0xC held upstream while FULL
    vecs[4]  = '{1'b1, 32'h0A, 1'b0, 1'b0,  1'b1, 32'h0A, 2'd1, 1'b1, 16'd0};
    vecs[5]  = '{1'b1, 32'h0B, 1'b0, 1'b0,  1'b1, 32'h0A, 2'd2, 1'b0, 16'd0};
    vecs[6]  = '{1'b1, 32'h0C, 1'b0, 1'b0,  1'b1, 32'h0A, 2'd2, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 32'hEE, 1'b0, 1'b0,  1'b1, 32'h0A, 2'd2, 1'b0, 16'd0};
    vecs[8]  = '{1'b1, 32'h0C, 1'b1, 1'b0,  1'b1, 32'h0B, 2'd1, 1'b1, 16'd0};
    vecs[9]  = '{1'b1, 32'h0C, 1'b1, 1'b0,  1'b1, 32'h0C, 2'd1, 1'b1, 16'd0};
    vecs[10] = '{1'b0, 32'h00, 1'b1, 1'b0,  1'b0, 32'h0C, 2'd0, 1'b1, 16'd0};
    // flush in FULL with in_valid and out_ready high
    vecs[11] = '{1'b1, 32'h44, 1'b0, 1'b0,  1'b1, 32'h44, 2'd1, 1'b1, 16'd0};
    vecs[12] = '{1'b1, 32'h55, 1'b0, 1'b0,  1'b1, 32'h44, 2'd2, 1'b0, 16'd0};
    vecs[13] = '{1'b1, 32'h66, 1'b1, 1'b1,  1'b0, 32'h00, 2'd0, 1'b1, 16'd2};
    // flush while EMPTY counts nothing; flush in ONE discards the same-cycle accept
    vecs[14] = '{1'b0, 32'h00, 1'b0, 1'b1,  1'b0, 32'h00, 2'd0, 1'b1, 16'd2};
    vecs[15] = '{1'b1, 32'h77, 1'b0, 1'b0,  1'b1, 32'h77, 2'd1, 1'b1, 16'd2};
    vecs[16] = '{1'b1, 32'h88, 1'b1, 1'b1,  1'b0, 32'h00, 2'd0, 1'b1, 16'd3};

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD;
    out_ready = 1'b1;
    flush     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 32'h0, 2'd0, 1'b1, 16'd0);
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].occ, vecs[i].ir, vecs[i].drop);
    end

    // Saturation: jump the counter near the top, then reach 0xFFFE by real FULL flushes.
    force dut.drop_q = 16'hFFF0;
    #1;
    release dut.drop_q;
    for (int i = 0; i < 7; i++) fill_and_flush();
    chk("sat.preload", {16'd0, drop_cnt}, 32'h0000FFFE);
    fill_and_flush();
    chk("sat.full_flush", {16'd0, drop_cnt}, 32'h0000FFFF);
    fill_and_flush();
    chk("sat.hold_full", {16'd0, drop_cnt}, 32'h0000FFFF);
    step(1'b1, 32'h99, 1'b0, 1'b0);
    step(1'b0, 32'h00, 1'b0, 1'b1);
    chk("sat.hold_one", {16'd0, drop_cnt}, 32'h0000FFFF);

    // Asynchronous reset in FULL, asserted between edges; controls held active must be ignored.
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 1'b0, 1'b0);
    chk("async.pre_full", {30'd0, occupancy}, 32'd2);
    #2;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    chk_all("async.immediate", 1'b0, 32'h0, 2'd0, 1'b1, 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all("async.held", 1'b0, 32'h0, 2'd0, 1'b1, 16'd0);
    rst = 1'b0;
    step(1'b1, 32'h5A, 1'b0, 1'b0);
    chk_all("async.first_push", 1'b1, 32'h5A, 2'd1, 1'b1, 16'd0);
    step(1'b0, 32'h00, 1'b1, 1'b0);
    chk_all("async.drain", 1'b0, 32'h5A, 2'd0, 1'b1, 16'd0);

    // Random valid/ready stress against an in-order queue model.
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("stress.occupancy", {30'd0, occupancy}, q.size());
      chk("stress.in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
      if (q.size() > 0) chk("stress.out_data", out_data, q[0]);
      else chk("stress.out_valid", {31'd0, out_valid}, 32'd0);
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 99) < 50);
      flush     = 1'b0;
      acc = in_valid & in_ready;
      pp  = out_valid & out_ready;
      if (pp && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(in_data);
      @(posedge clk);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stage_skid_buf.md
STAGE_SKID_BUF -- requirements
Module: stage_skid_buf

Interface
REQ-001 SHALL have parameter: WIDTH, 32, payload width in bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-high; the ports are named clk and rst.
REQ-003 SHALL have ports as follows:
  - clk  input  1  rising-edge clock.
  - rst  input  1  asynchronous active-high reset.
  - in_valid  input  1  upstream offers in_data.
  - in_ready  output  1  block can accept this cycle.
  - in_data  input  WIDTH  upstream payload.
  - out_valid  output  1  out_data holds a valid entry.
  - out_ready  input  1  downstream consumes this cycle.
  - out_data  output  WIDTH  head-of-buffer payload.
  - flush  input  1  synchronous discard of all entries.
  - occupancy  output  2  entries held, 0..2.
  - drop_cnt  output  16  saturating count of entries discarded by flush.

Function
REQ-004 SHALL hold two entries: main (drives out_data) and skid; states EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-005 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready, both sampled at the rising clk edge.
REQ-006 SHALL drive in_ready = 1 in EMPTY/ONE and 0 in FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-007 SHALL drive out_valid = 1 in ONE/FULL and 0 in EMPTY; out_data = main register.
REQ-008 EMPTY: accept -> ONE, main <= in_data; no accept -> stay.
REQ-009 ONE: accept & pop -> ONE, main <= in_data; accept & !pop -> FULL, skid <= in_data; pop & !accept -> EMPTY, main retained; neither -> stay.
REQ-010 FULL: pop -> ONE, main <= skid; no pop -> stay; in_data ignored.
REQ-011 SHALL have one-cycle latency from accept into EMPTY to out_valid = 1.
REQ-012 SHALL preserve strict FIFO order; no entry is duplicated or lost except by flush or reset.
REQ-013 SHALL keep out_data stable while out_valid = 1 and no pop occurs.
REQ-014 flush = 1 SHALL take priority over accept and pop in the same cycle: next state EMPTY; main and skid cleared to 0; the same-cycle accept is discarded and not counted.
REQ-015 On flush, drop_cnt SHALL add the pre-flush occupancy (0, 1 or 2), saturating at 16'hFFFF with no wrap.
REQ-016 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL; encoding 3 SHALL never appear.
REQ-017 SHALL treat an upstream in_valid drop while in_ready = 0 as legal; nothing is captured.

Reset
REQ-018 rst = 1 SHALL immediately, without clk, force state EMPTY, main = 0, skid = 0, drop_cnt = 0, out_valid = 0, occupancy = 0, in_ready = 1.
REQ-019 While rst = 1 the block SHALL ignore in_valid, out_ready and flush.
REQ-020 After rst deasserts, the first rising edge SHALL accept normally.
REQ-021 Reset asserted mid-operation, including in FULL, SHALL discard all entries without incrementing drop_cnt.

Verification
REQ-022 Streaming: out_ready = 1, push 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 one cycle later each; occupancy stays 1; in_ready stays 1.
REQ-023 Backpressure: out_ready = 0, push 0xA, 0xB, 0xC -> 0xA, 0xB accepted, occupancy 2, in_ready = 0, 0xC held upstream; raise out_ready -> 0xA, 0xB, 0xC emerge in order.
REQ-024 Flush in FULL with in_valid = 1 and out_ready = 1 -> next cycle occupancy 0, out_valid 0, out_data 0, drop_cnt +2, no pop or accept counted.
REQ-025 Saturation: preload drop_cnt to 0xFFFE via flushes, flush in FULL -> drop_cnt = 0xFFFF; further flushes leave 0xFFFF.
REQ-026 Async reset: in FULL, pulse rst between clk edges -> outputs reset immediately; after release, push 0x5A -> out_data 0x5A next cycle, drop_cnt 0.
REQ-027 Random valid/ready stress, 10k cycles -> output sequence equals accepted sequence; occupancy never 3; out_data never changes while out_valid & !out_ready.
